rom_prefetch_fetcher: RTL and testbench
=======================================

ROM_PREFETCH_FETCHER -- requirements
Module: rom_prefetch_fetcher

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- ADDR_W, 16, instruction address width.
- INSN_W, 16, instruction width; SHALL be an integer multiple of FL_DW.
- FL_DW, 8, flash data width.
- FL_AW, 22, flash byte-address width.
- WAIT_CYCLES, 1, extra cycles per flash beat before sampling.
- BASE_ADDR, 0, flash byte offset of instruction 0.
- PREFETCH, 1, 1 enables next-address prefetch; 0 makes the block demand-only.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, the only clock.
- reset, in, 1, asynchronous, active-high.
- req, in, 1, fetch request.
- addr, in, ADDR_W, instruction address; sampled with req.
- flush, in, 1, invalidates the prefetch buffer.
- insn, out, INSN_W, fetched instruction.
- insn_rdy, out, 1, insn valid for the last accepted req.
- busy, out, 1, req will not be accepted this cycle.
- pf_hit, out, 1, one-cycle pulse when a req is served from the prefetch buffer.
- fl_addr, out, FL_AW, flash address.
- fl_dq, in, FL_DW, flash read data.
- fl_oe_n, out, 1, flash output enable, active-low.
- fl_ce_n, out, 1, flash chip enable, active-low.

Function
REQ-003 BEATS = INSN_W/FL_DW; beat k of instruction A SHALL use fl_addr = BASE_ADDR + A*BEATS + k; beat 0 fills insn[FL_DW-1:0] (little-endian).
REQ-004 One beat SHALL last WAIT_CYCLES+1 cycles: fl_addr is driven in the first cycle and fl_dq is sampled on the last cycle's rising edge.
REQ-005 States SHALL be IDLE, DEMAND, PREFETCH.
REQ-006 busy SHALL be 1 in DEMAND; it SHALL be 0 in IDLE and PREFETCH.
REQ-007 A req is accepted when req=1 and busy=0. On acceptance, insn_rdy SHALL drop to 0 on the next edge unless the req is a prefetch hit.
REQ-008 Demand miss: IDLE -> DEMAND. insn_rdy SHALL rise exactly BEATS*(WAIT_CYCLES+1)+1 cycles after the accepting edge. insn SHALL hold its value and insn_rdy SHALL stay 1 until the next accepted req.
REQ-009 After a DEMAND fetch of A completes with PREFETCH=1, the FSM SHALL enter PREFETCH and fetch A+1 into a private buffer. The address increment wraps modulo 2^ADDR_W (0xFFFF -> 0x0000). Completion SHALL set pf_valid and return to IDLE.
REQ-010 Hit: req with addr == pf_addr and pf_valid=1. insn SHALL be loaded from the buffer with insn_rdy=1 one cycle after acceptance; pf_hit SHALL pulse in that same cycle. The FSM SHALL then start PREFETCH of addr+1.
REQ-011 A req during PREFETCH with addr == in-flight pf_addr SHALL complete the prefetch without restarting. insn_rdy SHALL rise one cycle after the final beat, and pf_hit SHALL pulse.
REQ-012 A req during PREFETCH with any other addr SHALL abort the prefetch on the accepting edge, clear pf_valid, and enter DEMAND for the new addr; partial beat data SHALL be discarded.
REQ-013 flush SHALL clear pf_valid. During PREFETCH, flush SHALL abort to IDLE. flush together with a req that would hit SHALL be treated as a miss. flush during DEMAND SHALL not disturb the demand fetch but SHALL suppress the following prefetch.
REQ-014 With PREFETCH=0, pf_valid SHALL stay 0 and the PREFETCH state SHALL be unreachable.
REQ-015 fl_ce_n and fl_oe_n SHALL be 0 while not in reset. fl_addr SHALL hold its last value in IDLE.

Reset
REQ-016 While reset=1 the block SHALL hold: state IDLE, insn=0, insn_rdy=0, busy=0, pf_hit=0, pf_valid=0, fl_addr=0, fl_oe_n=1, fl_ce_n=1.
REQ-017 Reset asserted mid-fetch SHALL abandon the fetch immediately. After reset deassertion, the first accepted req SHALL be a demand miss.

Structure
REQ-018 A shared package (gigatron_pkg) SHALL hold the FSM state type and default parameter constants; BEATS SHALL be a derived localparam in the module.
REQ-019 Beat timing and assembly SHALL live in one sub-module, flash_beat_reader: start, byte address and BEATS in; assembled word and done pulse out. It is reused for both demand and prefetch paths.

Verification
REQ-020 Scenarios, defaults (BEATS=2, beat=2 cycles):
- Demand miss: req addr=0x0010, fl_addr 0x20 -> data 0x34 and fl_addr 0x21 -> data 0x12 -> insn=0x1234, insn_rdy rises 5 cycles after accept, pf_hit=0.
- Sequential hit: after the above completes plus 4 idle cycles, req addr=0x0011 -> insn_rdy=1 after 1 cycle, pf_hit pulse, then fl_addr 0x24 is driven.
- Jump during prefetch: req 0x0010, then 1 cycle after insn_rdy, req 0x0200 -> prefetch aborted, next fl_addr=0x400, insn_rdy rises 5 cycles later, pf_hit=0.
- Wrap: req 0xFFFF -> prefetch fl_addr=0x0/0x1; req 0x0000 -> hit.
- Flush: after a prefetch of 0x0011 completes, assert flush, then req 0x0011 -> demand miss, 5-cycle latency.
- Reset mid-DEMAND: reset pulsed in the beat-1 cycle -> all outputs return to REQ-016 values; next req 0x0011 -> demand miss.

Source files
------------

// File: rtl/gigatron_pkg.sv
// Shared types and default parameter values for the ROM prefetch fetcher.
package gigatron_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDemand,
    StPrefetch
  } fetch_state_e;

  localparam int unsigned DefAddrW      = 16;
  localparam int unsigned DefInsnW      = 16;
  localparam int unsigned DefFlDw       = 8;
  localparam int unsigned DefFlAw       = 22;
  localparam int unsigned DefWaitCycles = 1;
  localparam int unsigned DefBaseAddr   = 0;
  localparam int unsigned DefPrefetch   = 1;

endpackage

// File: rtl/flash_beat_reader.sv
// Reads BEATS consecutive flash bytes/words starting at a byte address and
// assembles them little-endian into one instruction word.
module flash_beat_reader #(
  parameter int unsigned INSN_W      = 16,
  parameter int unsigned FL_DW       = 8,
  parameter int unsigned FL_AW       = 22,
  parameter int unsigned BEATS       = 2,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [FL_AW-1:0]  byte_addr,
  input  logic [FL_DW-1:0]  fl_dq,
  output logic [FL_AW-1:0]  fl_addr,
  output logic [INSN_W-1:0] word,
  output logic              done
);

  localparam int unsigned BeatW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned WaitW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  logic              active_q;
  logic [BeatW-1:0]  beat_q;
  logic [WaitW-1:0]  wait_q;
  logic [FL_AW-1:0]  fl_addr_q;
  logic [INSN_W-1:0] word_q;
  logic              done_q;

  // start wins over an in-flight read so a jump can restart without a bubble
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q  <= 1'b0;
      beat_q    <= '0;
      wait_q    <= '0;
      fl_addr_q <= '0;
      word_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        active_q  <= 1'b1;
        fl_addr_q <= byte_addr;
        beat_q    <= '0;
        wait_q    <= '0;
      end else if (abort) begin
        active_q <= 1'b0;
      end else if (active_q) begin
        if (wait_q == WaitW'(WAIT_CYCLES)) begin
          for (int k = 0; k < int'(BEATS); k++) begin
            if (beat_q == BeatW'(k)) word_q[k*FL_DW +: FL_DW] <= fl_dq;
          end
          if (beat_q == BeatW'(BEATS - 1)) begin
            active_q <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            beat_q    <= beat_q + 1'b1;
            fl_addr_q <= fl_addr_q + 1'b1;
            wait_q    <= '0;
          end
        end else begin
          wait_q <= wait_q + 1'b1;
        end
      end
    end
  end

  assign fl_addr = fl_addr_q;
  assign word    = word_q;
  assign done    = done_q;

endmodule

// File: rtl/rom_prefetch_fetcher.sv
// Instruction fetcher over a narrow flash with a one-entry next-address
// prefetch buffer; demand and prefetch share one beat reader.
module rom_prefetch_fetcher
  import gigatron_pkg::*;
#(
  parameter int unsigned ADDR_W      = DefAddrW,
  parameter int unsigned INSN_W      = DefInsnW,
  parameter int unsigned FL_DW       = DefFlDw,
  parameter int unsigned FL_AW       = DefFlAw,
  parameter int unsigned WAIT_CYCLES = DefWaitCycles,
  parameter int unsigned BASE_ADDR   = DefBaseAddr,
  parameter int unsigned PREFETCH    = DefPrefetch
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic              flush,
  output logic [INSN_W-1:0] insn,
  output logic              insn_rdy,
  output logic              busy,
  output logic              pf_hit,
  output logic [FL_AW-1:0]  fl_addr,
  input  logic [FL_DW-1:0]  fl_dq,
  output logic              fl_oe_n,
  output logic              fl_ce_n
);

  localparam int unsigned BEATS = INSN_W / FL_DW;

  function automatic logic [FL_AW-1:0] byte_addr(input logic [ADDR_W-1:0] a);
    return FL_AW'(BASE_ADDR) + FL_AW'(a) * FL_AW'(BEATS);
  endfunction

  fetch_state_e      state_q, state_d;
  logic [INSN_W-1:0] insn_q, insn_d, pf_buf_q, pf_buf_d;
  logic              insn_rdy_q, insn_rdy_d, pf_hit_q, pf_hit_d;
  logic              pf_valid_q, pf_valid_d, claim_q, claim_d;
  logic              supp_q, supp_d, hit_pend_q, hit_pend_d;
  logic [ADDR_W-1:0] pf_addr_q, pf_addr_d, dem_addr_q, dem_addr_d;
  logic [ADDR_W-1:0] addr_next, pf_next, dem_next;
  logic              accept, pf_req_hit;
  logic              rd_start, rd_abort, rd_done;
  logic [FL_AW-1:0]  rd_addr;
  logic [INSN_W-1:0] rd_word;

  assign busy       = (state_q == StDemand);
  assign accept     = req && !busy;
  assign pf_req_hit = accept && (addr == pf_addr_q) && !flush;
  assign addr_next  = addr + 1'b1;
  assign pf_next    = pf_addr_q + 1'b1;
  assign dem_next   = dem_addr_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    insn_d     = insn_q;
    insn_rdy_d = insn_rdy_q;
    pf_hit_d   = 1'b0;
    pf_valid_d = pf_valid_q;
    pf_addr_d  = pf_addr_q;
    pf_buf_d   = pf_buf_q;
    dem_addr_d = dem_addr_q;
    claim_d    = claim_q;
    supp_d     = supp_q;
    hit_pend_d = 1'b0;
    rd_start   = 1'b0;
    rd_abort   = 1'b0;
    rd_addr    = byte_addr(addr);

    // buffer hit accepted last cycle is presented now
    if (hit_pend_q) begin
      insn_d     = pf_buf_q;
      insn_rdy_d = 1'b1;
      pf_hit_d   = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (pf_valid_q && (addr == pf_addr_q) && !flush) begin
            hit_pend_d = 1'b1;
            pf_valid_d = 1'b0;
            pf_addr_d  = addr_next;
            rd_start   = 1'b1;
            rd_addr    = byte_addr(addr_next);
            state_d    = StPrefetch;
          end else begin
            insn_rdy_d = 1'b0;
            pf_valid_d = 1'b0;
            dem_addr_d = addr;
            supp_d     = 1'b0;
            rd_start   = 1'b1;
            state_d    = StDemand;
          end
        end else if (flush) begin
          pf_valid_d = 1'b0;
        end
      end
      StDemand: begin
        if (flush) supp_d = 1'b1;
        if (rd_done) begin
          insn_d     = rd_word;
          insn_rdy_d = 1'b1;
          supp_d     = 1'b0;
          if ((PREFETCH != 0) && !supp_q && !flush) begin
            pf_addr_d = dem_next;
            rd_start  = 1'b1;
            rd_addr   = byte_addr(dem_next);
            state_d   = StPrefetch;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StPrefetch: begin
        if (accept && !pf_req_hit) begin
          claim_d    = 1'b0;
          pf_valid_d = 1'b0;
          insn_rdy_d = 1'b0;
          dem_addr_d = addr;
          supp_d     = 1'b0;
          rd_start   = 1'b1;
          state_d    = StDemand;
        end else begin
          if (pf_req_hit) begin
            claim_d    = 1'b1;
            insn_rdy_d = 1'b0;
          end
          if (rd_done) begin
            if (claim_q || pf_req_hit) begin
              insn_d     = rd_word;
              insn_rdy_d = 1'b1;
              pf_hit_d   = 1'b1;
              claim_d    = 1'b0;
              pf_addr_d  = pf_next;
              rd_start   = 1'b1;
              rd_addr    = byte_addr(pf_next);
            end else begin
              pf_buf_d   = rd_word;
              pf_valid_d = !flush;
              state_d    = StIdle;
            end
          end else if (flush) begin
            if (claim_q) begin
              // a claimed prefetch still owes the requester its instruction
              claim_d    = 1'b0;
              dem_addr_d = pf_addr_q;
              supp_d     = 1'b0;
              rd_start   = 1'b1;
              rd_addr    = byte_addr(pf_addr_q);
              state_d    = StDemand;
            end else begin
              rd_abort   = 1'b1;
              pf_valid_d = 1'b0;
              state_d    = StIdle;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      insn_q     <= '0;
      insn_rdy_q <= 1'b0;
      pf_hit_q   <= 1'b0;
      pf_valid_q <= 1'b0;
      pf_addr_q  <= '0;
      pf_buf_q   <= '0;
      dem_addr_q <= '0;
      claim_q    <= 1'b0;
      supp_q     <= 1'b0;
      hit_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      insn_q     <= insn_d;
      insn_rdy_q <= insn_rdy_d;
      pf_hit_q   <= pf_hit_d;
      pf_valid_q <= pf_valid_d;
      pf_addr_q  <= pf_addr_d;
      pf_buf_q   <= pf_buf_d;
      dem_addr_q <= dem_addr_d;
      claim_q    <= claim_d;
      supp_q     <= supp_d;
      hit_pend_q <= hit_pend_d;
    end
  end

  flash_beat_reader #(
    .INSN_W      (INSN_W),
    .FL_DW       (FL_DW),
    .FL_AW       (FL_AW),
    .BEATS       (BEATS),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_reader (
    .clk       (clk),
    .reset     (reset),
    .start     (rd_start),
    .abort     (rd_abort),
    .byte_addr (rd_addr),
    .fl_dq     (fl_dq),
    .fl_addr   (fl_addr),
    .word      (rd_word),
    .done      (rd_done)
  );

  assign insn     = insn_q;
  assign insn_rdy = insn_rdy_q;
  assign pf_hit   = pf_hit_q;
  assign fl_ce_n  = reset;
  assign fl_oe_n  = reset;

endmodule

// File: tb/tb_rom_prefetch_fetcher.sv
// Directed bench for rom_prefetch_fetcher with a combinational flash model.
module tb_rom_prefetch_fetcher;

  logic        clk;
  logic        reset;
  logic        req;
  logic [15:0] addr;
  logic        flush;
  logic [15:0] insn;
  logic        insn_rdy;
  logic        busy;
  logic        pf_hit;
  logic [21:0] fl_addr;
  logic [7:0]  fl_dq;
  logic        fl_oe_n;
  logic        fl_ce_n;

  int n_checks = 0;
  int n_errors = 0;

  rom_prefetch_fetcher dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .addr     (addr),
    .flush    (flush),
    .insn     (insn),
    .insn_rdy (insn_rdy),
    .busy     (busy),
    .pf_hit   (pf_hit),
    .fl_addr  (fl_addr),
    .fl_dq    (fl_dq),
    .fl_oe_n  (fl_oe_n),
    .fl_ce_n  (fl_ce_n)
  );

  // 0x20 -> 0x34, 0x21 -> 0x12, 0x400 -> 0x18, 0x401 -> 0xF6, ...
  always_comb fl_dq = (fl_addr[7:0] ^ fl_addr[15:8]) + (fl_addr[0] ? 8'hF1 : 8'h14);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] a, output int lat, output int hits,
                       output logic [21:0] fl0, output logic busy0, output logic rdy0);
    req  = 1'b1;
    addr = a;
    tick();
    req   = 1'b0;
    fl0   = fl_addr;
    busy0 = busy;
    rdy0  = insn_rdy;
    hits  = int'(pf_hit);
    lat   = 0;
    do begin
      tick();
      lat++;
      hits += int'(pf_hit);
    end while (!insn_rdy && lat < 40);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_insn"}, 32'(insn), 32'h0);
    check({tag, "_rdy"}, 32'(insn_rdy), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_pf_hit"}, 32'(pf_hit), 32'h0);
    check({tag, "_fl_addr"}, 32'(fl_addr), 32'h0);
    check({tag, "_oe_n"}, 32'(fl_oe_n), 32'h1);
    check({tag, "_ce_n"}, 32'(fl_ce_n), 32'h1);
  endtask

  int          lat;
  int          hits;
  logic [21:0] fl0;
  logic        busy0;
  logic        rdy0;

  initial begin
    reset = 1'b1;
    req   = 1'b0;
    addr  = '0;
    flush = 1'b0;
    tick();
    tick();
    check_reset_values("rst");
    reset = 1'b0;
    #1;
    check("ce_after_rst", 32'(fl_ce_n), 32'h0);
    check("oe_after_rst", 32'(fl_oe_n), 32'h0);

    // demand miss of 0x0010
    issue(16'h0010, lat, hits, fl0, busy0, rdy0);
    check("miss_fl0", 32'(fl0), 32'h20);
    check("miss_busy", 32'(busy0), 32'h1);
    check("miss_rdy_drop", 32'(rdy0), 32'h0);
    check("miss_lat", 32'(lat), 32'd5);
    check("miss_insn", 32'(insn), 32'h1234);
    check("miss_hits", 32'(hits), 32'h0);
    check("pf_fl_addr", 32'(fl_addr), 32'h22);
    check("pf_busy", 32'(busy), 32'h0);

    // sequential hit on 0x0011
    repeat (5) tick();
    issue(16'h0011, lat, hits, fl0, busy0, rdy0);
    check("hit_busy", 32'(busy0), 32'h0);
    check("hit_fl0", 32'(fl0), 32'h24);
    check("hit_lat", 32'(lat), 32'd1);
    check("hit_hits", 32'(hits), 32'd1);
    check("hit_insn", 32'(insn), 32'h1436);
    tick();
    check("hit_pulse_end", 32'(pf_hit), 32'h0);

    // jump during prefetch
    repeat (6) tick();
    check("hold_insn", 32'(insn), 32'h1436);
    check("hold_rdy", 32'(insn_rdy), 32'h1);
    issue(16'h0010, lat, hits, fl0, busy0, rdy0);
    check("jmp_pre_lat", 32'(lat), 32'd5);
    issue(16'h0200, lat, hits, fl0, busy0, rdy0);
    check("jmp_fl0", 32'(fl0), 32'h400);
    check("jmp_busy", 32'(busy0), 32'h1);
    check("jmp_rdy_drop", 32'(rdy0), 32'h0);
    check("jmp_lat", 32'(lat), 32'd5);
    check("jmp_insn", 32'(insn), 32'hF618);
    check("jmp_hits", 32'(hits), 32'h0);

    // address wrap 0xFFFF -> 0x0000
    repeat (6) tick();
    issue(16'hFFFF, lat, hits, fl0, busy0, rdy0);
    check("wrap_fl0", 32'(fl0), 32'h1FFFE);
    check("wrap_lat", 32'(lat), 32'd5);
    check("wrap_insn", 32'(insn), 32'hF115);
    check("wrap_pf_b0", 32'(fl_addr), 32'h0);
    tick();
    tick();
    check("wrap_pf_b1", 32'(fl_addr), 32'h1);
    repeat (4) tick();
    issue(16'h0000, lat, hits, fl0, busy0, rdy0);
    check("wrap_hit_lat", 32'(lat), 32'd1);
    check("wrap_hit_hits", 32'(hits), 32'd1);
    check("wrap_hit_insn", 32'(insn), 32'hF214);

    // flush invalidates a completed prefetch of 0x0011
    repeat (6) tick();
    issue(16'h0010, lat, hits, fl0, busy0, rdy0);
    repeat (6) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    issue(16'h0011, lat, hits, fl0, busy0, rdy0);
    check("flush_rdy_drop", 32'(rdy0), 32'h0);
    check("flush_fl0", 32'(fl0), 32'h22);
    check("flush_lat", 32'(lat), 32'd5);
    check("flush_hits", 32'(hits), 32'h0);
    check("flush_insn", 32'(insn), 32'h1436);

    // reset in the second beat of a demand fetch
    repeat (6) tick();
    req  = 1'b1;
    addr = 16'h0030;
    tick();
    req = 1'b0;
    tick();
    tick();
    check("mid_fl_addr", 32'(fl_addr), 32'h61);
    reset = 1'b1;
    #1;
    check_reset_values("midrst");
    tick();
    reset = 1'b0;
    issue(16'h0011, lat, hits, fl0, busy0, rdy0);
    check("postrst_busy", 32'(busy0), 32'h1);
    check("postrst_lat", 32'(lat), 32'd5);
    check("postrst_hits", 32'(hits), 32'h0);
    check("postrst_insn", 32'(insn), 32'h1436);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
